// File: rtl/multi_channel_fifo_pkg.sv
// ---------------------------------------------------------------------------
// multi_channel_fifo_pkg
//   Shared helpers for the multi-channel FIFO slice. All widths come from
//   module parameters, so the package holds only width-independent helpers.
// ---------------------------------------------------------------------------
package multi_channel_fifo_pkg;

    // Channel index reached by stepping 'offset' places past 'base', wrapping at n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/multi_channel_fifo_sc_fifo_showahead.sv
// ---------------------------------------------------------------------------
// sc_fifo_showahead
//   Single-clock first-word-fall-through FIFO, 2**LOG_DEPTH entries.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     clear          synchronous flush (pointers and count), wins over push/pop
//     push/push_data write request and word; ignored while full
//     pop            remove head word; ignored while empty
//     head_data      current head word (combinational, show-ahead)
//     empty, full    derived from the registered count
//     usedw          stored-entry count, 0..2**LOG_DEPTH
//     overflow       push attempted while full (word dropped)
// ---------------------------------------------------------------------------
module sc_fifo_showahead #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOG_DEPTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic [LOG_DEPTH:0]    usedw,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic [LOG_DEPTH:0]    count;
    logic                  wr_en;
    logic                  rd_en;

    assign full      = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty     = (count == '0);
    assign usedw     = count;
    assign head_data = mem[rd_ptr];

    assign wr_en    = push & ~full & ~clear;
    assign rd_en    = pop & ~empty & ~clear;
    assign overflow = push & full & ~clear;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_fifo.sv
// ---------------------------------------------------------------------------
// multi_channel_fifo
//   N independent show-ahead FIFOs merged by a round-robin arbiter into one
//   registered valid/ready stream tagged with the source channel.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     clear        synchronous flush of FIFOs, errors and arbiter state
//     push_en      per-channel write request
//     push_data    channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//     push_full    per-channel full flag
//     usedw        per-channel count, (LOG_DEPTH+1) bits each
//     pop_ready    consumer accepts the output word
//     pop_valid    output register holds a word
//     pop_data     output word
//     pop_channel  source channel of pop_data
//     error        sticky per-channel overflow flag
// ---------------------------------------------------------------------------
module multi_channel_fifo
    import multi_channel_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned LOG_DEPTH  = 5,
    parameter  int unsigned N_CHANNELS = 4,
    localparam int unsigned CH_W       = $clog2(N_CHANNELS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [N_CHANNELS-1:0]               push_en,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]    push_data,
    output logic [N_CHANNELS-1:0]               push_full,
    output logic [N_CHANNELS*(LOG_DEPTH+1)-1:0] usedw,
    input  logic                                pop_ready,
    output logic                                pop_valid,
    output logic [DATA_WIDTH-1:0]               pop_data,
    output logic [CH_W-1:0]                     pop_channel,
    output logic [N_CHANNELS-1:0]               error
);

    logic [N_CHANNELS-1:0] empty;
    logic [N_CHANNELS-1:0] overflow;
    logic [N_CHANNELS-1:0] pop;
    logic [DATA_WIDTH-1:0] head [N_CHANNELS];
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  grant_found;
    logic                  out_free;

    assign out_free = ~pop_valid | pop_ready;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        sc_fifo_showahead #(
            .DATA_WIDTH (DATA_WIDTH),
            .LOG_DEPTH  (LOG_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .push      (push_en[i]),
            .push_data (push_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop[i]),
            .head_data (head[i]),
            .empty     (empty[i]),
            .full      (push_full[i]),
            .usedw     (usedw[i*(LOG_DEPTH+1) +: (LOG_DEPTH+1)]),
            .overflow  (overflow[i])
        );

        assign pop[i] = out_free & grant_found & (grant_idx == CH_W'(i)) & ~clear;
    end

    // Search starts one past the last grant; the offset runs to N so the
    // last-granted channel itself is considered last.
    always_comb begin
        logic [CH_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_CHANNELS; k++) begin
            cand = CH_W'(rr_index(32'(last_grant), k, N_CHANNELS));
            if (!grant_found && !empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid   <= 1'b0;
            pop_data    <= '0;
            pop_channel <= '0;
            last_grant  <= CH_W'(N_CHANNELS - 1);
        end else if (clear) begin
            pop_valid   <= 1'b0;
            last_grant  <= CH_W'(N_CHANNELS - 1);
        end else if (out_free) begin
            if (grant_found) begin
                pop_valid   <= 1'b1;
                pop_data    <= head[grant_idx];
                pop_channel <= grant_idx;
                last_grant  <= grant_idx;
            end else begin
                pop_valid   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= '0;
        end else if (clear) begin
            error <= '0;
        end else begin
            error <= error | overflow;
        end
    end

endmodule

// File: tb/tb_multi_channel_fifo.sv
module tb_multi_channel_fifo;

    localparam int DW    = 32;
    localparam int LD    = 5;
    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clear;
    logic [NCH-1:0]         push_en;
    logic [NCH*DW-1:0]      push_data;
    logic [NCH-1:0]         push_full;
    logic [NCH*(LD+1)-1:0]  usedw;
    logic                   pop_ready;
    logic                   pop_valid;
    logic [DW-1:0]          pop_data;
    logic [CW-1:0]          pop_channel;
    logic [NCH-1:0]         error;

    int n_cmp = 0;
    int n_err = 0;

    multi_channel_fifo #(
        .DATA_WIDTH (DW),
        .LOG_DEPTH  (LD),
        .N_CHANNELS (NCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .push_en     (push_en),
        .push_data   (push_data),
        .push_full   (push_full),
        .usedw       (usedw),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .pop_channel (pop_channel),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus the output word.
    logic [DW-1:0] mq [NCH][$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_last;
    bit [NCH-1:0]  m_err;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_valid = 0;
        m_data  = '0;
        m_ch    = 0;
        m_last  = NCH - 1;
        m_err   = '0;
    endfunction

    function automatic void model_edge();
        int  sz [NCH];
        int  g;
        bit  free;
        if (clear) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_valid = 0;
            m_err   = '0;
            m_last  = NCH - 1;
            return;
        end
        for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
        free = !m_valid || pop_ready;
        g = -1;
        if (free) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (g < 0 && sz[c] > 0) g = c;
            end
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_ch    = g;
                m_valid = 1;
                m_last  = g;
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (push_en[c]) begin
                if (sz[c] == DEPTH) m_err[c] = 1'b1;
                else mq[c].push_back(push_data[c*DW +: DW]);
            end
        end
    endfunction

    task automatic check_all();
        chk("pop_valid", 64'(pop_valid), 64'(m_valid));
        if (m_valid) begin
            chk("pop_data", 64'(pop_data), 64'(m_data));
            chk("pop_channel", 64'(pop_channel), 64'(m_ch));
        end
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("usedw[%0d]", c), 64'(usedw[c*(LD+1) +: (LD+1)]), 64'(mq[c].size()));
            chk($sformatf("push_full[%0d]", c), 64'(push_full[c]), 64'(mq[c].size() == DEPTH));
            chk($sformatf("error[%0d]", c), 64'(error[c]), 64'(m_err[c]));
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        push_en   = '0;
        push_data = '0;
        clear     = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = NCH'($urandom);
            for (int c = 0; c < NCH; c++) push_data[c*DW +: DW] = $urandom;
            pop_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        pop_ready = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word on channel 2
        pop_ready = 1'b1;
        push_en   = 4'b0100;
        push_data[2*DW +: DW] = 32'hA5;
        step();
        idle_inputs();
        repeat (4) step();

        // Three words per channel, then drain with pop_ready high
        pop_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            push_en = '1;
            for (int c = 0; c < NCH; c++) push_data[c*DW +: DW] = 32'(c * 16 + r);
            step();
        end
        idle_inputs();
        pop_ready = 1'b1;
        repeat (16) step();

        // Overflow channel 1 with the consumer stalled
        pop_ready = 1'b0;
        for (int i = 0; i < 34; i++) begin
            push_en = 4'b0010;
            push_data[1*DW +: DW] = 32'(1000 + i);
            step();
        end
        idle_inputs();
        pop_ready = 1'b1;
        repeat (40) step();

        // Channel 0 streams 0..15 while pop_ready toggles
        for (int i = 0; i < 40; i++) begin
            pop_ready = i[0];
            if (i < 16) begin
                push_en = 4'b0001;
                push_data[DW-1:0] = 32'(i);
            end else begin
                push_en = '0;
            end
            step();
        end
        idle_inputs();

        // Clear mid-stream, then a fresh push on channel 3
        pop_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            push_en = 4'b1111;
            for (int c = 0; c < NCH; c++) push_data[c*DW +: DW] = $urandom;
            step();
        end
        clear   = 1'b1;
        push_en = 4'b0110;
        step();
        idle_inputs();
        push_en = 4'b1000;
        push_data[3*DW +: DW] = 32'h3333;
        step();
        idle_inputs();
        pop_ready = 1'b1;
        repeat (3) step();

        random_cycles(2000);

        // Asynchronous reset between edges with data in flight
        pop_ready = 1'b0;
        push_en   = 4'b1011;
        for (int c = 0; c < NCH; c++) push_data[c*DW +: DW] = $urandom;
        step();
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst pop_valid", 64'(pop_valid), 64'd0);
        chk("async_rst pop_data", 64'(pop_data), 64'd0);
        chk("async_rst pop_channel", 64'(pop_channel), 64'd0);
        chk("async_rst usedw", 64'(usedw), 64'd0);
        chk("async_rst push_full", 64'(push_full), 64'd0);
        chk("async_rst error", 64'(error), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        random_cycles(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
